hud_digit_encoder: RTL and testbench
====================================

Name: hud_digit_encoder

Overview:
- Converts per-car HUD quantities (speed magnitude, lap count, mass level) into decimal digit codes for the status-bar digit renderer.
- On each frame-start pulse it snapshots the game-state values and converts them serially with double-dabble.
- It then commits all digits atomically, so the bar never shows a half-updated number within a frame.
- Sits between the game/physics logic (producer of binary values) and the bar digit SRAM lookup (consumer of digit codes).

Parameters:
- SPEED_WIDTH, 7, width of unsigned speed magnitude (equals game_pkg VELOCITY_OUTPUT_WIDTH).
- BLANK_LEADING, 1, 1 = leading-zero speed digits output as DIGIT_BLANK.
- DIGIT_SAT, 9, saturation value for lap and level digits.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_frame_start  input  1  one-cycle pulse, start of frame
- i_car1_speed  input  SPEED_WIDTH  car1 speed magnitude, unsigned
- i_car2_speed  input  SPEED_WIDTH  car2 speed magnitude, unsigned
- i_car1_lap  input  4  car1 completed laps
- i_car2_lap  input  4  car2 completed laps
- i_car1_level  input  4  car1 mass level
- i_car2_level  input  4  car2 mass level
- o_car1_spd_digits  output  12  {hundred, ten, one} 4-bit codes
- o_car2_spd_digits  output  12  {hundred, ten, one} 4-bit codes
- o_car1_lap_digit  output  4  lap digit code
- o_car2_lap_digit  output  4  lap digit code
- o_car1_level_digit  output  4  level digit code
- o_car2_level_digit  output  4  level digit code
- o_busy  output  1  conversion in progress
- o_update  output  1  one-cycle pulse, new digits committed
- o_overrun  output  1  sticky: frame_start arrived while busy

Behaviour:
- Reset is asynchronous and active-low.
  - Digit outputs reset to 0, except speed hundred/ten digits, which reset to DIGIT_BLANK (4'hF) when BLANK_LEADING=1.
  - o_busy, o_update and o_overrun reset to 0; FSM resets to IDLE.
- Digit codes: 0-9 decimal, 4'hF = DIGIT_BLANK; codes 10-14 are never output.
- FSM states: IDLE, CONV1, CONV2, COMMIT.
- IDLE: when i_frame_start=1 at an edge:
  - snapshot all six inputs into shadow registers;
  - clear the BCD shift register (12 bits) and the bit counter;
  - go to CONV1; o_busy=1 from the next cycle.
- CONV1: one double-dabble step per cycle on the car1 speed.
  - Add 3 to any BCD nibble >=5, then shift left, taking in the MSB of the speed shadow.
  - After SPEED_WIDTH steps, store the car1 BCD result, reload for car2, go to CONV2.
- CONV2: same SPEED_WIDTH steps for car2, then go to COMMIT.
- COMMIT, in one edge:
  - all 12 output digit codes update simultaneously;
  - o_update=1 for exactly one cycle; o_busy drops; return to IDLE.
- Latency: frame_start sampled at edge N gives outputs and o_update valid after edge N+2*SPEED_WIDTH+1 (=15 with defaults).
- Outputs hold stable between commits.
- Blanking (BLANK_LEADING=1):
  - hundred = BLANK if it is 0;
  - ten = BLANK if hundred and ten are both 0;
  - one is always shown.
- Lap/level digit = min(input, DIGIT_SAT). Lap 10 (LAP_MAX) displays 9. No blanking on lap/level.
- i_frame_start while busy (or in COMMIT): ignored, o_overrun set. It is cleared only by reset.
- Input changes during conversion have no effect; only the snapshot is used.
- Reset mid-conversion: the FSM returns to IDLE, outputs take reset values, and no o_update pulse is produced.

Decomposition:
- Add to game_pkg:
  - DIGIT_BLANK (4'hF);
  - HUD_BCD_WIDTH (12);
  - a HudFsmState enum (IDLE/CONV1/CONV2/COMMIT).
- The existing VelocityDisplayDigit enum indexes the 12-bit speed field: HUNDRED=[11:8], TEN=[7:4], ONE=[3:0].
- Sub-module bcd_dabble_step: combinational, one add-3-and-shift step over 3 nibbles plus 1 input bit. It is instantiated once and shared by CONV1 and CONV2.

Test Plan:
- Reset, then one frame_start with speeds 127/0, laps 3/0, levels 5/5:
  - 15 cycles later o_update pulses;
  - car1 speed = {1,2,7}, car2 speed = {F,F,0}, laps 3/0, levels 5/5.
- Speed 5 and speed 40, BLANK_LEADING=1: digits {F,F,5} and {F,4,0}. Same with BLANK_LEADING=0: {0,0,5} and {0,4,0}.
- Lap input 10 and 15, level input 12: lap digits 9/9, level digit 9.
- frame_start at cycle 0 and again at cycle 5: exactly one o_update, at cycle 15; o_overrun=1 afterwards and stays 1.
- Change i_car1_speed from 100 to 3 at cycle 4 of a conversion: committed digits are {1,0,0}.
- Assert i_rst_n=0 at cycle 8 of a conversion:
  - outputs return immediately to their reset values; o_busy=0; no o_update pulse;
  - the next frame_start converts normally.

Source files
------------

// File: rtl/hud_digit_encoder_pkg.sv
// Shared HUD constants, digit index enum, FSM state type and digit formatting helpers.
package hud_digit_encoder_pkg;

  localparam int VELOCITY_OUTPUT_WIDTH = 7;
  localparam int HUD_BCD_WIDTH         = 12;
  localparam logic [3:0] DIGIT_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    ONE     = 2'd0,
    TEN     = 2'd1,
    HUNDRED = 2'd2
  } velocity_display_digit_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV1  = 2'd1,
    CONV2  = 2'd2,
    COMMIT = 2'd3
  } hud_fsm_state_e;

  // Only leading zeros are blanked; the ones digit always shows, so zero reads as "0".
  function automatic logic [HUD_BCD_WIDTH-1:0] hud_blank_speed(
    input logic [HUD_BCD_WIDTH-1:0] bcd,
    input logic                     blank_en
  );
    logic [HUD_BCD_WIDTH-1:0] r;
    r = bcd;
    if (blank_en && (bcd[4*int'(HUNDRED) +: 4] == 4'd0)) begin
      r[4*int'(HUNDRED) +: 4] = DIGIT_BLANK;
      if (bcd[4*int'(TEN) +: 4] == 4'd0) begin
        r[4*int'(TEN) +: 4] = DIGIT_BLANK;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] hud_sat_digit(input logic [3:0] v, input logic [3:0] sat);
    return (v > sat) ? sat : v;
  endfunction

endpackage

// File: rtl/hud_digit_encoder_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module bcd_dabble_step
  import hud_digit_encoder_pkg::*;
(
  input  logic [HUD_BCD_WIDTH-1:0] bcd_i,
  input  logic                     bit_i,
  output logic [HUD_BCD_WIDTH-1:0] bcd_o
);

  logic [HUD_BCD_WIDTH-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int n = 0; n < HUD_BCD_WIDTH / 4; n++) begin
      if (adj[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
      end
    end
    bcd_o = {adj[HUD_BCD_WIDTH-2:0], bit_i};
  end

endmodule

// File: rtl/hud_digit_encoder.sv
// Snapshots HUD values on frame start, converts both speeds serially to BCD,
// then commits all digit codes in one edge with a single-cycle update pulse.
module hud_digit_encoder
  import hud_digit_encoder_pkg::*;
#(
  parameter int SPEED_WIDTH   = VELOCITY_OUTPUT_WIDTH,
  parameter int BLANK_LEADING = 1,
  parameter int DIGIT_SAT     = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic [SPEED_WIDTH-1:0]   i_car1_speed,
  input  logic [SPEED_WIDTH-1:0]   i_car2_speed,
  input  logic [3:0]               i_car1_lap,
  input  logic [3:0]               i_car2_lap,
  input  logic [3:0]               i_car1_level,
  input  logic [3:0]               i_car2_level,
  output logic [HUD_BCD_WIDTH-1:0] o_car1_spd_digits,
  output logic [HUD_BCD_WIDTH-1:0] o_car2_spd_digits,
  output logic [3:0]               o_car1_lap_digit,
  output logic [3:0]               o_car2_lap_digit,
  output logic [3:0]               o_car1_level_digit,
  output logic [3:0]               o_car2_level_digit,
  output logic                     o_busy,
  output logic                     o_update,
  output logic                     o_overrun
);

  localparam int CNT_W = $clog2(SPEED_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED_WIDTH - 1);
  localparam logic BLANK_EN = (BLANK_LEADING != 0);
  localparam logic [3:0] SAT = 4'(DIGIT_SAT);
  localparam logic [HUD_BCD_WIDTH-1:0] SPD_RST =
    BLANK_EN ? {DIGIT_BLANK, DIGIT_BLANK, 4'h0} : '0;

  hud_fsm_state_e           state_q;
  logic [SPEED_WIDTH-1:0]   shift_q;
  logic [SPEED_WIDTH-1:0]   spd2_q;
  logic [3:0]               lap1_q, lap2_q, lvl1_q, lvl2_q;
  logic [HUD_BCD_WIDTH-1:0] bcd_q;
  logic [HUD_BCD_WIDTH-1:0] bcd_d;
  logic [HUD_BCD_WIDTH-1:0] car1_bcd_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [HUD_BCD_WIDTH-1:0] spd1_out_q, spd2_out_q;
  logic [3:0]               lap1_out_q, lap2_out_q, lvl1_out_q, lvl2_out_q;
  logic                     busy_q, update_q, overrun_q;

  // Single step instance serves both cars; the FSM reloads its operands between them.
  bcd_dabble_step u_step (
    .bcd_i (bcd_q),
    .bit_i (shift_q[SPEED_WIDTH-1]),
    .bcd_o (bcd_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      spd2_q     <= '0;
      lap1_q     <= '0;
      lap2_q     <= '0;
      lvl1_q     <= '0;
      lvl2_q     <= '0;
      bcd_q      <= '0;
      car1_bcd_q <= '0;
      cnt_q      <= '0;
      spd1_out_q <= SPD_RST;
      spd2_out_q <= SPD_RST;
      lap1_out_q <= '0;
      lap2_out_q <= '0;
      lvl1_out_q <= '0;
      lvl2_out_q <= '0;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (i_frame_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_frame_start) begin
            shift_q <= i_car1_speed;
            spd2_q  <= i_car2_speed;
            lap1_q  <= i_car1_lap;
            lap2_q  <= i_car2_lap;
            lvl1_q  <= i_car1_level;
            lvl2_q  <= i_car2_level;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV1;
          end
        end
        CONV1: begin
          if (cnt_q == CNT_LAST) begin
            car1_bcd_q <= bcd_d;
            bcd_q      <= '0;
            shift_q    <= spd2_q;
            cnt_q      <= '0;
            state_q    <= CONV2;
          end else begin
            bcd_q   <= bcd_d;
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        CONV2: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_q << 1;
          if (cnt_q == CNT_LAST) begin
            state_q <= COMMIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          spd1_out_q <= hud_blank_speed(car1_bcd_q, BLANK_EN);
          spd2_out_q <= hud_blank_speed(bcd_q, BLANK_EN);
          lap1_out_q <= hud_sat_digit(lap1_q, SAT);
          lap2_out_q <= hud_sat_digit(lap2_q, SAT);
          lvl1_out_q <= hud_sat_digit(lvl1_q, SAT);
          lvl2_out_q <= hud_sat_digit(lvl2_q, SAT);
          update_q   <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_car1_spd_digits  = spd1_out_q;
  assign o_car2_spd_digits  = spd2_out_q;
  assign o_car1_lap_digit   = lap1_out_q;
  assign o_car2_lap_digit   = lap2_out_q;
  assign o_car1_level_digit = lvl1_out_q;
  assign o_car2_level_digit = lvl2_out_q;
  assign o_busy             = busy_q;
  assign o_update           = update_q;
  assign o_overrun          = overrun_q;

endmodule

// File: tb/tb_hud_digit_encoder.sv
// Scoreboard bench: two encoders (leading blanking on / off) share stimulus; monitors pop expectations on o_update.
module tb_hud_digit_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic [6:0]  spd1 = '0, spd2 = '0;
  logic [3:0]  lap1 = '0, lap2 = '0, lvl1 = '0, lvl2 = '0;

  logic [11:0] a_s1, a_s2, b_s1, b_s2;
  logic [3:0]  a_l1, a_l2, a_v1, a_v2, b_l1, b_l2, b_v1, b_v2;
  logic        a_busy, a_upd, a_ovr, b_busy, b_upd, b_ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [11:0] s1, s2;
    logic [3:0]  l1, l2, v1, v2;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hud_digit_encoder #(.SPEED_WIDTH(7), .BLANK_LEADING(1), .DIGIT_SAT(9)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame),
    .i_car1_speed(spd1), .i_car2_speed(spd2),
    .i_car1_lap(lap1), .i_car2_lap(lap2),
    .i_car1_level(lvl1), .i_car2_level(lvl2),
    .o_car1_spd_digits(a_s1), .o_car2_spd_digits(a_s2),
    .o_car1_lap_digit(a_l1), .o_car2_lap_digit(a_l2),
    .o_car1_level_digit(a_v1), .o_car2_level_digit(a_v2),
    .o_busy(a_busy), .o_update(a_upd), .o_overrun(a_ovr)
  );

  hud_digit_encoder #(.SPEED_WIDTH(7), .BLANK_LEADING(0), .DIGIT_SAT(9)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame),
    .i_car1_speed(spd1), .i_car2_speed(spd2),
    .i_car1_lap(lap1), .i_car2_lap(lap2),
    .i_car1_level(lvl1), .i_car2_level(lvl2),
    .o_car1_spd_digits(b_s1), .o_car2_spd_digits(b_s2),
    .o_car1_lap_digit(b_l1), .o_car2_lap_digit(b_l2),
    .o_car1_level_digit(b_v1), .o_car2_level_digit(b_v2),
    .o_busy(b_busy), .o_update(b_upd), .o_overrun(b_ovr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drives one frame pulse at a negedge; expected digits for both instances are queued if push=1.
  task automatic frame_pulse(
    input logic [6:0] s1, input logic [6:0] s2,
    input logic [3:0] l1, input logic [3:0] l2, input logic [3:0] v1, input logic [3:0] v2,
    input logic [11:0] ea1, input logic [11:0] ea2, input logic [11:0] eb1, input logic [11:0] eb2,
    input logic [3:0] el1, input logic [3:0] el2, input logic [3:0] ev1, input logic [3:0] ev2,
    input bit push
  );
    exp_t e;
    @(negedge clk);
    spd1 = s1; spd2 = s2; lap1 = l1; lap2 = l2; lvl1 = v1; lvl2 = v2;
    frame = 1'b1;
    e.l1 = el1; e.l2 = el2; e.v1 = ev1; e.v2 = ev2;
    e.cyc = cyc + 16;
    if (push) begin
      e.s1 = ea1; e.s2 = ea2; q_a.push_back(e);
      e.s1 = eb1; e.s2 = eb2; q_b.push_back(e);
    end
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e,
                         input logic [11:0] s1, input logic [11:0] s2,
                         input logic [3:0] l1, input logic [3:0] l2,
                         input logic [3:0] v1, input logic [3:0] v2);
    check({tag, "_spd1"}, 32'(s1), 32'(e.s1));
    check({tag, "_spd2"}, 32'(s2), 32'(e.s2));
    check({tag, "_lap1"}, 32'(l1), 32'(e.l1));
    check({tag, "_lap2"}, 32'(l2), 32'(e.l2));
    check({tag, "_lvl1"}, 32'(v1), 32'(e.v1));
    check({tag, "_lvl2"}, 32'(v2), 32'(e.v2));
    check({tag, "_latency_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (a_upd === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_update", 32'd1, 32'd0);
      end else begin
        compare("a", q_a.pop_front(), a_s1, a_s2, a_l1, a_l2, a_v1, a_v2);
      end
    end
  end

  always @(negedge clk) begin
    if (b_upd === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_update", 32'd1, 32'd0);
      end else begin
        compare("b", q_b.pop_front(), b_s1, b_s2, b_l1, b_l2, b_v1, b_v2);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_a_spd1"}, 32'(a_s1), 32'h0FF0);
    check({tag, "_a_spd2"}, 32'(a_s2), 32'h0FF0);
    check({tag, "_b_spd1"}, 32'(b_s1), 32'h0000);
    check({tag, "_b_spd2"}, 32'(b_s2), 32'h0000);
    check({tag, "_a_laps_lvls"}, 32'({a_l1, a_l2, a_v1, a_v2}), 32'h0);
    check({tag, "_b_laps_lvls"}, 32'({b_l1, b_l2, b_v1, b_v2}), 32'h0);
    check({tag, "_flags"}, 32'({a_busy, a_upd, a_ovr, b_busy, b_upd, b_ovr}), 32'h0);
  endtask

  initial begin
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 127/0, laps 3/0, levels 5/5
    frame_pulse(7'd127, 7'd0, 4'd3, 4'd0, 4'd5, 4'd5,
                12'h127, 12'hFF0, 12'h127, 12'h000, 4'd3, 4'd0, 4'd5, 4'd5, 1'b1);
    check("busy_after_start", 32'({a_busy, b_busy}), 32'h3);
    repeat (20) @(negedge clk);
    check("busy_idle", 32'({a_busy, b_busy}), 32'h0);

    // Small speeds exercise blanking; lap/level saturation
    frame_pulse(7'd5, 7'd40, 4'd10, 4'd15, 4'd12, 4'd0,
                12'hFF5, 12'hF40, 12'h005, 12'h040, 4'd9, 4'd9, 4'd9, 4'd0, 1'b1);
    repeat (20) @(negedge clk);
    check("no_overrun_yet", 32'({a_ovr, b_ovr}), 32'h0);

    // Second frame pulse while busy is dropped and flagged
    frame_pulse(7'd99, 7'd100, 4'd1, 4'd9, 4'd9, 4'd1,
                12'hF99, 12'h100, 12'h099, 12'h100, 4'd1, 4'd9, 4'd9, 4'd1, 1'b1);
    repeat (4) @(negedge clk);
    frame = 1'b1;
    spd1 = 7'd1;
    @(negedge clk);
    frame = 1'b0;
    check("overrun_set", 32'({a_ovr, b_ovr}), 32'h3);
    repeat (20) @(negedge clk);
    check("overrun_sticky", 32'({a_ovr, b_ovr}), 32'h3);

    // Inputs changing mid-conversion must not leak into the result
    frame_pulse(7'd100, 7'd10, 4'd2, 4'd7, 4'd8, 4'd4,
                12'h100, 12'hF10, 12'h100, 12'h010, 4'd2, 4'd7, 4'd8, 4'd4, 1'b1);
    repeat (2) @(negedge clk);
    spd1 = 7'd3; spd2 = 7'd77; lap1 = 4'd0; lvl2 = 4'd15;
    repeat (20) @(negedge clk);

    // Reset mid-conversion: no update, reset values, then normal operation
    frame_pulse(7'd64, 7'd64, 4'd4, 4'd4, 4'd4, 4'd4,
                12'h0, 12'h0, 12'h0, 12'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_still_idle", 32'({a_busy, b_busy}), 32'h0);

    frame_pulse(7'd9, 7'd120, 4'd0, 4'd10, 4'd3, 4'd13,
                12'hFF9, 12'h120, 12'h009, 12'h120, 4'd0, 4'd9, 4'd3, 4'd9, 1'b1);
    repeat (20) @(negedge clk);

    check("a_all_updates_seen", 32'(q_a.size()), 32'd0);
    check("b_all_updates_seen", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
